// File: rtl/sha256_pkg.sv
// Shared definitions for the SHA-256 message front-end: initial hash value,
// controller state encoding, word/block widths and small helpers.
package sha256_pkg;

  localparam int unsigned WORD_W  = 32;
  localparam int unsigned BLOCK_W = 512;
  localparam int unsigned NWORDS  = BLOCK_W / WORD_W;

  localparam logic [255:0] SHA256_IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;

  // Word written to a fresh slot when the 0x80 marker could not share the last data word.
  localparam logic [WORD_W-1:0] PAD_WORD = 32'h8000_0000;

  typedef enum logic [2:0] {
    FILL = 3'd0,
    PAD  = 3'd1,
    HASH = 3'd2,
    WAIT = 3'd3,
    DONE = 3'd4
  } msg_state_t;

  // Number of message bits carried by a beat with the given byte count.
  function automatic logic [63:0] keep_to_bits(input logic [2:0] keep);
    return {58'd0, keep, 3'b000};
  endfunction

endpackage

// File: rtl/sha256_pad_merge.sv
// Inserts the 0x80 padding marker directly after the valid bytes of a
// left-aligned word and clears the bytes that follow it. A full word
// (keep = 4) passes through unchanged; the marker then goes to the next slot.
module sha256_pad_merge
  import sha256_pkg::*;
(
  input  logic [WORD_W-1:0] i_data,
  input  logic [2:0]        i_keep,
  output logic [WORD_W-1:0] o_word
);

  // Select the merged word according to the number of valid bytes.
  always_comb begin
    o_word = i_data;
    case (i_keep)
      3'd0:    o_word = 32'h8000_0000;
      3'd1:    o_word = {i_data[31:24], 24'h80_0000};
      3'd2:    o_word = {i_data[31:16], 16'h8000};
      3'd3:    o_word = {i_data[31:8], 8'h80};
      default: o_word = i_data;
    endcase
  end

endmodule

// File: rtl/sha256_msg_ctrl.sv
// SHA-256 message front-end: takes a byte-granular big-endian word stream,
// appends the 0x80 marker, zero fill and 64-bit length, issues 512-bit blocks
// to the block core, chains intermediate hashes and hands out the digest.
// Optional build macro SHA256_MSG_CTRL_MIDSTATE_EN adds mid_H/mid_len/mid_load
// so a message can resume from a previously computed chaining state.
module sha256_msg_ctrl
  import sha256_pkg::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 in_valid,
  output logic                 in_ready,
  input  logic [WORD_W-1:0]    in_data,
  input  logic [2:0]           in_keep,
  input  logic                 in_last,
  output logic                 blk_start,
  output logic [255:0]         blk_H,
  output logic [BLOCK_W-1:0]   blk_M,
  input  logic [255:0]         blk_H_out,
  input  logic                 blk_done,
  output logic [255:0]         digest,
  output logic                 digest_valid,
`ifdef SHA256_MSG_CTRL_MIDSTATE_EN
  input  logic [255:0]         mid_H,
  input  logic [63:0]          mid_len,
  input  logic                 mid_load,
`endif
  input  logic                 digest_ready
);

  msg_state_t                    r_state;
  msg_state_t                    w_next;
  logic [0:NWORDS-1][WORD_W-1:0] r_buf;
  logic [3:0]                    r_widx;
  logic [63:0]                   r_len;
  logic [255:0]                  r_chain;
  logic [255:0]                  r_digest;
  logic                          r_in_ready;
  logic                          r_blk_start;
  logic                          r_digest_valid;
  logic                          r_final;     // current block carries the length
  logic                          r_extra;     // one more padding-only block follows
  logic                          r_pend80;    // 0x80 still owed as a whole word
  logic                          r_nofit;     // marker landed in slot 14/15
  logic                          r_full;      // buffer filled by the last data word

  logic                          w_accept;
  logic                          w_pad_wr;
  logic [WORD_W-1:0]             w_pad_word;
  logic                          w_pad_len;
  logic [WORD_W-1:0]             w_merged;
  logic                          w_mid_take;
  logic [255:0]                  w_mid_h;
  logic [63:0]                   w_mid_len;

  sha256_pad_merge u_merge (
    .i_data (in_data),
    .i_keep (in_keep),
    .o_word (w_merged)
  );

`ifdef SHA256_MSG_CTRL_MIDSTATE_EN
  logic r_issued;  // a block of the current message has gone to the core

  assign w_mid_take = (r_state == FILL) && !w_accept && mid_load &&
                      (r_widx == 4'd0) && !r_issued;
  assign w_mid_h    = mid_H;
  assign w_mid_len  = mid_len;

  // Track whether the running message has issued a block; midstate loads only before that.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_issued <= 1'b0;
    end else if (r_state == HASH) begin
      r_issued <= 1'b1;
    end else if ((r_state == DONE) && r_digest_valid && digest_ready) begin
      r_issued <= 1'b0;
    end else begin
      r_issued <= r_issued;
    end
  end
`else
  assign w_mid_take = 1'b0;
  assign w_mid_h    = SHA256_IV;
  assign w_mid_len  = 64'd0;
`endif

  // Next-state logic and the padding word produced in PAD.
  always_comb begin
    w_next     = r_state;
    w_accept   = 1'b0;
    w_pad_wr   = 1'b0;
    w_pad_word = 32'h0000_0000;
    w_pad_len  = 1'b0;
    case (r_state)
      FILL: begin
        w_accept = in_valid && r_in_ready;
        if (w_accept && in_last) begin
          w_next = PAD;
        end else if (w_accept && (r_widx == 4'd15)) begin
          w_next = HASH;
        end else begin
          w_next = FILL;
        end
      end
      PAD: begin
        if (r_full) begin
          w_next = HASH;
        end else begin
          w_pad_wr = 1'b1;
          if (r_pend80) begin
            w_pad_word = PAD_WORD;
          end else if (!r_nofit && (r_widx == 4'd14)) begin
            w_pad_word = r_len[63:32];
          end else if (!r_nofit && (r_widx == 4'd15)) begin
            w_pad_word = r_len[31:0];
            w_pad_len  = 1'b1;
          end else begin
            w_pad_word = 32'h0000_0000;
          end
          if (r_widx == 4'd15) begin
            w_next = HASH;
          end else begin
            w_next = PAD;
          end
        end
      end
      HASH: begin
        w_next = WAIT;
      end
      WAIT: begin
        if (blk_done && r_final) begin
          w_next = DONE;
        end else if (blk_done && r_extra) begin
          w_next = PAD;
        end else if (blk_done) begin
          w_next = FILL;
        end else begin
          w_next = WAIT;
        end
      end
      DONE: begin
        if (r_digest_valid && digest_ready) begin
          w_next = FILL;
        end else begin
          w_next = DONE;
        end
      end
      default: begin
        w_next = FILL;
      end
    endcase
  end

  // State register, registered handshake outputs and the block datapath.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state        <= FILL;
      r_in_ready     <= 1'b0;
      r_blk_start    <= 1'b0;
      r_digest_valid <= 1'b0;
      r_digest       <= 256'd0;
      r_chain        <= SHA256_IV;
      r_len          <= 64'd0;
      r_widx         <= 4'd0;
      r_buf          <= '0;
      r_final        <= 1'b0;
      r_extra        <= 1'b0;
      r_pend80       <= 1'b0;
      r_nofit        <= 1'b0;
      r_full         <= 1'b0;
    end else begin
      r_state        <= w_next;
      r_in_ready     <= (w_next == FILL);
      r_blk_start    <= (w_next == HASH);
      r_digest_valid <= (w_next == DONE);
      case (r_state)
        FILL: begin
          if (w_accept) begin
            r_buf[r_widx] <= w_merged;
            r_widx        <= r_widx + 4'd1;
            r_len         <= r_len + keep_to_bits(in_keep);
            if (in_last) begin
              r_pend80 <= (in_keep >= 3'd4);
              r_nofit  <= (in_keep < 3'd4) && (r_widx >= 4'd14);
              r_full   <= (r_widx == 4'd15);
            end else begin
              r_pend80 <= r_pend80;
            end
          end else if (w_mid_take) begin
            r_chain <= w_mid_h;
            r_len   <= w_mid_len;
          end else begin
            r_widx <= r_widx;
          end
        end
        PAD: begin
          if (w_pad_wr) begin
            r_buf[r_widx] <= w_pad_word;
            r_widx        <= r_widx + 4'd1;
            if (r_pend80) begin
              r_pend80 <= 1'b0;
              r_nofit  <= (r_widx >= 4'd14);
            end else begin
              r_pend80 <= r_pend80;
            end
            if (r_widx == 4'd15) begin
              r_final <= w_pad_len;
              r_extra <= !w_pad_len;
            end else begin
              r_final <= r_final;
            end
          end else begin
            r_full  <= 1'b0;
            r_extra <= 1'b1;
          end
        end
        WAIT: begin
          if (blk_done) begin
            r_chain <= blk_H_out;
            r_widx  <= 4'd0;
            if (r_final) begin
              r_digest <= blk_H_out;
            end else begin
              r_extra <= 1'b0;
              r_nofit <= 1'b0;
            end
          end else begin
            r_chain <= r_chain;
          end
        end
        DONE: begin
          if (r_digest_valid && digest_ready) begin
            r_chain  <= SHA256_IV;
            r_len    <= 64'd0;
            r_widx   <= 4'd0;
            r_final  <= 1'b0;
            r_extra  <= 1'b0;
            r_pend80 <= 1'b0;
            r_nofit  <= 1'b0;
            r_full   <= 1'b0;
          end else begin
            r_chain <= r_chain;
          end
        end
        default: begin
          r_widx <= r_widx;
        end
      endcase
    end
  end

  assign in_ready     = r_in_ready;
  assign blk_start    = r_blk_start;
  assign blk_H        = r_chain;
  assign blk_M        = r_buf;
  assign digest       = r_digest;
  assign digest_valid = r_digest_valid;

endmodule

// File: tb/tb_sha256_msg_ctrl.sv
// Self-checking bench for sha256_msg_ctrl with a behavioural SHA-256 block
// core. Known-answer digests plus a byte-level padding reference model.
module tb_sha256_msg_ctrl;

  localparam logic [255:0] IV =
    256'h6a09e667_bb67ae85_3c6ef372_a54ff53a_510e527f_9b05688c_1f83d9ab_5be0cd19;
  localparam int LAT = 4;
  localparam logic [31:0] K [0:63] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5, 32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3, 32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc, 32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7, 32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13, 32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3, 32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5, 32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208, 32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2};
  localparam logic [255:0] D_ABC =
    256'hba7816bf_8f01cfea_414140de_5dae2223_b00361a3_96177a9c_b410ff61_f20015ad;

  logic         clk = 1'b0;
  logic         rst, in_valid, in_ready, in_last, blk_start, blk_done;
  logic         digest_valid, digest_ready;
  logic [31:0]  in_data;
  logic [2:0]   in_keep;
  logic [255:0] blk_H, blk_H_out, digest;
  logic [511:0] blk_M;
`ifdef SHA256_MSG_CTRL_MIDSTATE_EN
  logic [255:0] mid_H;
  logic [63:0]  mid_len;
  logic         mid_load;
`endif

  int n_checks = 0;
  int n_fail   = 0;
  int blk_cnt  = 0;
  logic core_en   = 1'b1;
  logic spur_done = 1'b0;
  logic [511:0] blkM [0:63];
  logic [255:0] blkH [0:63];

  sha256_msg_ctrl dut (
    .clk          (clk),
    .rst          (rst),
    .in_valid     (in_valid),
    .in_ready     (in_ready),
    .in_data      (in_data),
    .in_keep      (in_keep),
    .in_last      (in_last),
    .blk_start    (blk_start),
    .blk_H        (blk_H),
    .blk_M        (blk_M),
    .blk_H_out    (blk_H_out),
    .blk_done     (blk_done),
    .digest       (digest),
    .digest_valid (digest_valid),
`ifdef SHA256_MSG_CTRL_MIDSTATE_EN
    .mid_H        (mid_H),
    .mid_len      (mid_len),
    .mid_load     (mid_load),
`endif
    .digest_ready (digest_ready)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] ror(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic logic [255:0] compress(input logic [255:0] h, input logic [511:0] m);
    logic [31:0] w [0:63];
    logic [31:0] a, b, c, d, e, f, g, hh, t1, t2, s0, s1;
    for (int t = 0; t < 16; t++) w[t] = m[511 - 32*t -: 32];
    for (int t = 16; t < 64; t++) begin
      s0 = ror(w[t-15], 7) ^ ror(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror(w[t-2], 17) ^ ror(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    {a, b, c, d, e, f, g, hh} = h;
    for (int t = 0; t < 64; t++) begin
      t1 = hh + (ror(e, 6) ^ ror(e, 11) ^ ror(e, 25)) + ((e & f) ^ (~e & g)) + K[t] + w[t];
      t2 = (ror(a, 2) ^ ror(a, 13) ^ ror(a, 22)) + ((a & b) ^ (a & c) ^ (b & c));
      hh = g; g = f; f = e; e = d + t1; d = c; c = b; b = a; a = t1 + t2;
    end
    return {h[255:224] + a, h[223:192] + b, h[191:160] + c, h[159:128] + d,
            h[127:96] + e, h[95:64] + f, h[63:32] + g, h[31:0] + hh};
  endfunction

  // Byte-level reference: message of (nw-1)*4+lk bytes, padded and hashed from IV.
  function automatic logic [255:0] sha_ref(input logic [0:16][31:0] w, input int nw, input int lk);
    logic [7:0]   bt [0:191];
    logic [63:0]  bits;
    logic [511:0] m;
    logic [255:0] h;
    int n, nb;
    n = (nw - 1) * 4 + lk;
    for (int i = 0; i < 192; i++) bt[i] = 8'h00;
    for (int i = 0; i < n; i++) bt[i] = w[i/4][31 - 8*(i%4) -: 8];
    bt[n] = 8'h80;
    nb = (n + 9 + 63) / 64;
    bits = 64'(n) * 64'd8;
    for (int i = 0; i < 8; i++) bt[nb*64 - 1 - i] = bits[8*i +: 8];
    h = IV;
    for (int k = 0; k < nb; k++) begin
      for (int j = 0; j < 64; j++) m[511 - 8*j -: 8] = bt[k*64 + j];
      h = compress(h, m);
    end
    return h;
  endfunction

  // Block core model: latches a job on blk_start, answers LAT cycles later.
  initial begin
    logic [255:0] res;
    int cd;
    cd = 0;
    res = '0;
    blk_done = 1'b0;
    blk_H_out = '0;
    forever begin
      @(negedge clk);
      blk_done = 1'b0;
      if (spur_done) begin
        blk_done = 1'b1;
        blk_H_out = 256'hdead_beef;
      end else if (cd == 1) begin
        blk_done = 1'b1;
        blk_H_out = res;
        cd = 0;
      end else if (cd > 1) begin
        cd--;
      end
      if (blk_start) begin
        blkM[blk_cnt & 63] = blk_M;
        blkH[blk_cnt & 63] = blk_H;
        blk_cnt++;
        if (core_en) begin
          res = compress(blk_H, blk_M);
          cd = LAT;
        end
      end
    end
  end

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: actual %h required %h", name, act, exp);
    end
  endtask

  task automatic send_word(input logic [31:0] d, input logic [2:0] k, input logic l);
    int t;
    t = 0;
    in_data = d; in_keep = k; in_last = l; in_valid = 1'b1;
    while (!in_ready && t < 300) begin
      @(negedge clk);
      t++;
    end
    if (!in_ready) begin
      check("in_ready timeout", {255'd0, in_ready}, 256'd1);
    end
    @(negedge clk);
    in_valid = 1'b0;
  endtask

  task automatic send_msg(input logic [0:16][31:0] w, input int nw, input int lk);
    for (int i = 0; i < nw; i++) begin
      send_word(w[i], (i == nw - 1) ? 3'(lk) : 3'd4, i == nw - 1);
    end
  endtask

  task automatic wait_digest(input string name, input logic [255:0] exp);
    int t;
    t = 0;
    while (!digest_valid && t < 2000) begin
      @(negedge clk);
      t++;
    end
    check({name, " valid"}, {255'd0, digest_valid}, 256'd1);
    check({name, " digest"}, digest, exp);
    check({name, " in_ready low"}, {255'd0, in_ready}, 256'd0);
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    check({name, " in_ready back"}, {255'd0, in_ready}, 256'd1);
  endtask

  typedef struct {
    logic [0:16][31:0] w;
    int                nw;
    int                lk;
    int                nblk;
    logic [31:0]       w0;
    logic [255:0]      dig;
  } vec_t;

  vec_t tab [0:7];

  // Global time limit so a stuck design still ends the run.
  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [0:16][31:0] pat, tw;
    string s;
    int base, n, b0, t;

    rst = 1'b1; in_valid = 1'b0; in_data = '0; in_keep = '0; in_last = 1'b0;
    digest_ready = 1'b0;
`ifdef SHA256_MSG_CTRL_MIDSTATE_EN
    mid_H = '0; mid_len = '0; mid_load = 1'b0;
`endif
    for (int i = 0; i < 17; i++) pat[i] = {8'(4*i), 8'(4*i+1), 8'(4*i+2), 8'(4*i+3)};
    s = "abcdbcdecdefdefgefghfghighijhijkijkljklmklmnlmnomnopnopq";
    tw = '0;
    for (int i = 0; i < 56; i++) tw[i/4][31 - 8*(i%4) -: 8] = s[i];

    tab[0] = '{w: {32'h61626300, 512'd0}, nw: 1, lk: 3, nblk: 1, w0: 32'h61626380, dig: D_ABC};
    tab[1] = '{w: '0, nw: 1, lk: 0, nblk: 1, w0: 32'h80000000,
               dig: 256'he3b0c442_98fc1c14_9afbf4c8_996fb924_27ae41e4_649b934c_a495991b_7852b855};
    tab[2] = '{w: tw, nw: 14, lk: 4, nblk: 2, w0: 32'h61626364,
               dig: 256'h248d6a61_d20638b8_e5c02693_0c3e6039_a33ce459_64ff2167_f6ecedd4_19db06c1};
    tab[3] = '{w: {32'h61ffffff, 512'd0}, nw: 1, lk: 1, nblk: 1, w0: 32'h61800000,
               dig: 256'hca978112_ca1bbdca_fac231b3_9a23dc4d_a786eff8_147c4e72_b9807785_afee48bb};
    tab[4] = '{w: pat, nw: 14, lk: 3, nblk: 1, w0: 32'h00010203, dig: sha_ref(pat, 14, 3)};
    tab[5] = '{w: pat, nw: 15, lk: 4, nblk: 2, w0: 32'h00010203, dig: sha_ref(pat, 15, 4)};
    tab[6] = '{w: pat, nw: 16, lk: 2, nblk: 2, w0: 32'h00010203, dig: sha_ref(pat, 16, 2)};
    tab[7] = '{w: pat, nw: 16, lk: 4, nblk: 2, w0: 32'h00010203, dig: sha_ref(pat, 16, 4)};

    // Reset state
    @(negedge clk); @(negedge clk);
    check("reset in_ready", {255'd0, in_ready}, 256'd0);
    check("reset blk_start", {255'd0, blk_start}, 256'd0);
    check("reset digest_valid", {255'd0, digest_valid}, 256'd0);
    check("reset digest", digest, 256'd0);
    rst = 1'b0;
    @(negedge clk);
    check("post-reset in_ready", {255'd0, in_ready}, 256'd1);
    check("post-reset chain", blk_H, IV);

    // Table-driven messages
    for (int v = 0; v < 8; v++) begin
      base = blk_cnt;
      n = (tab[v].nw - 1) * 4 + tab[v].lk;
      send_msg(tab[v].w, tab[v].nw, tab[v].lk);
      wait_digest($sformatf("v%0d", v), tab[v].dig);
      check($sformatf("v%0d blocks", v), 256'(blk_cnt - base), 256'(tab[v].nblk));
      check($sformatf("v%0d first H", v), blkH[base & 63], IV);
      check($sformatf("v%0d word0", v), {224'd0, blkM[base & 63][511:480]}, {224'd0, tab[v].w0});
      check($sformatf("v%0d length", v), {192'd0, blkM[(blk_cnt - 1) & 63][63:0]}, 256'(8 * n));
    end

    // Back-pressure on the digest
    send_word(32'h61626300, 3'd3, 1'b1);
    t = 0;
    while (!digest_valid && t < 2000) begin @(negedge clk); t++; end
    for (int i = 0; i < 20; i++) begin
      check($sformatf("bp valid %0d", i), {255'd0, digest_valid}, 256'd1);
      check($sformatf("bp digest %0d", i), digest, D_ABC);
      check($sformatf("bp in_ready %0d", i), {255'd0, in_ready}, 256'd0);
      @(negedge clk);
    end
    digest_ready = 1'b1;
    @(negedge clk);
    digest_ready = 1'b0;
    send_word(32'h61626300, 3'd3, 1'b1);
    wait_digest("bp next abc", D_ABC);

    // Reset while waiting on the core, then a spurious blk_done
    core_en = 1'b0;
    b0 = blk_cnt;
    send_word(32'h61626300, 3'd3, 1'b1);
    t = 0;
    while (blk_cnt == b0 && t < 100) begin @(negedge clk); t++; end
    check("rw block issued", 256'(blk_cnt - b0), 256'd1);
    @(negedge clk); @(negedge clk);
    rst = 1'b1;
    @(negedge clk); @(negedge clk);
    check("rw reset in_ready", {255'd0, in_ready}, 256'd0);
    rst = 1'b0;
    spur_done = 1'b1;
    @(negedge clk); @(negedge clk); @(negedge clk);
    spur_done = 1'b0;
    @(negedge clk); @(negedge clk);
    check("rw no digest", {255'd0, digest_valid}, 256'd0);
    check("rw in_ready", {255'd0, in_ready}, 256'd1);
    check("rw chain", blk_H, IV);
    core_en = 1'b1;
    send_word(32'h61626300, 3'd3, 1'b1);
    wait_digest("rw abc", D_ABC);

`ifdef SHA256_MSG_CTRL_MIDSTATE_EN
    // Resume from a midstate: first 64 bytes pre-hashed, 3-byte tail streamed
    mid_H = compress(IV, pat[0:15]);
    mid_len = 64'd512;
    mid_load = 1'b1;
    @(negedge clk);
    mid_load = 1'b0;
    send_word(pat[16], 3'd3, 1'b1);
    wait_digest("midstate", sha_ref(pat, 17, 3));
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
